branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Execute-stage branch/jump sequencer for the RISC-V core. Takes the comparator result for conditional branches,
//  which is always 1 for JAL/JALR. Computes the target and drives a one-cycle PC redirect to fetch.
//  Then holds a front-end flush window. Also raises the misaligned-target exception and keeps saturating branch/taken counters.
// PARAMETERS
//  XLEN       32  data/address width
//  FLUSH_CYC  2   cycles flush_fe is held per redirect (1..15), including the redirect cycle
//  CNT_W      16  width of performance counters
// PORTS
//  clk             in   1      core clock
//  rst_n           in   1      reset, asynchronous, active-low
//  valid_de        in   1      instruction valid in DE/EX register
//  ready_de        out  1      controller can accept a branch/jump this cycle
//  br_type_de      in   2      00 none, 01 cond branch, 10 JAL, 11 JALR
//  pc_de           in   XLEN   PC of instruction
//  imm_de          in   XLEN   sign-extended immediate
//  rs1data_de      in   XLEN   rs1 operand (JALR base)
//  comp_out        in   1      comparator result for the current instruction's funct3
//  stall_ex        in   1      back-end stall; blocks acceptance
//  cnt_clr         in   1      synchronous clear of both counters
//  redirect_valid  out  1      one-cycle redirect pulse to fetch
//  redirect_pc     out  XLEN   redirect target
//  flush_fe        out  1      kill instructions in IF/ID
//  misalign_exc    out  1      one-cycle pulse: taken target not 4-byte aligned
//  branch_cnt      out  CNT_W  accepted branches/jumps, saturating
//  taken_cnt       out  CNT_W  redirects issued, saturating
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; all outputs 0; ready_de=1 after reset deasserts.
//  - ready_de = (state==IDLE). Accept = valid_de & ready_de & ~stall_ex & (br_type_de!=00).
//  - br_type_de==00 with valid_de has no effect. It is not counted.
//  - Target arithmetic is modulo 2^XLEN; carry is discarded.
//    - cond/JAL: tgt = pc_de + imm_de.
//    - JALR: tgt = (rs1data_de + imm_de) & ~1.
//  - taken = comp_out for cond; 1 for JAL/JALR. comp_out is sampled only on the accept cycle.
//  - On accept: branch_cnt+1.
//    - If taken & tgt[1]==0: go to REDIR and register redirect_pc=tgt.
//    - If taken & tgt[1]==1: misalign_exc=1 next cycle for 1 cycle; no redirect; stay IDLE.
//    - If not taken: stay IDLE with zero bubbles.
//  - FSM:
//    - IDLE -> REDIR on taken & aligned.
//    - REDIR lasts 1 cycle: redirect_valid=1, flush_fe=1, taken_cnt+1. Exit to FLUSH if FLUSH_CYC>1, else to IDLE.
//    - FLUSH: flush_fe=1, down-counter of FLUSH_CYC-1 cycles, then IDLE.
//  - Latency: redirect_valid is asserted exactly 1 cycle after the accept edge.
//    ready_de is low for FLUSH_CYC cycles, starting with the REDIR cycle.
//  - stall_ex does not pause REDIR/FLUSH sequencing; it only gates acceptance.
//  - redirect_pc holds its last value outside REDIR.
//  - Counters saturate at all-ones. cnt_clr has priority over an increment in the same cycle.
// TESTING
//  1. cond, pc=0x100, imm=0x20, comp_out=0 -> no redirect, ready_de stays 1, branch_cnt=1, taken_cnt=0.
//  2. cond, pc=0x100, imm=0x20, comp_out=1 -> next cycle redirect_valid=1, redirect_pc=0x120;
//     flush_fe=1 and ready_de=0 for 2 cycles; taken_cnt=1.
//  3. JALR, rs1=0x2001, imm=0x4 -> redirect_pc=0x2004 (bit0 cleared).
//     JAL, pc=0xFFFF_FFF0, imm=0x20 -> redirect_pc=0x0000_0010 (wrap).
//  4. JAL, pc=0x100, imm=0x6 -> misalign_exc pulse 1 cycle, no redirect_valid, ready_de stays 1.
//  5. Taken branch with stall_ex=1 on the offered cycle -> not accepted.
//     Raise stall_ex during FLUSH -> flush still ends after FLUSH_CYC cycles.
//  6. rst_n low in FLUSH -> outputs 0 immediately, IDLE after release.
//     With CNT_W=4, 20 taken jumps -> both counters=15; cnt_clr with a concurrent accept -> 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch/jump sequencer: computes the taken target, issues a
// one-cycle redirect to fetch, holds the front-end flush window, flags
// misaligned targets and keeps saturating branch/taken counters.
module branch_redirect_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_de,
    output logic             ready_de,
    input  logic [1:0]       br_type_de,
    input  logic [XLEN-1:0]  pc_de,
    input  logic [XLEN-1:0]  imm_de,
    input  logic [XLEN-1:0]  rs1data_de,
    input  logic             comp_out,
    input  logic             stall_ex,
    input  logic             cnt_clr,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_fe,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {StIdle, StRedir, StFlush} state_e;

    // Cycles spent in StFlush after the redirect cycle.
    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYC - 1);

    state_e           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             is_jalr;
    logic [XLEN-1:0]  tgt_base;
    logic [XLEN-1:0]  tgt_sum;
    logic [XLEN-1:0]  tgt;
    logic             taken;
    logic             accept;

    // Target and taken decode for the offered instruction.
    always_comb begin
        is_jalr  = (br_type_de == 2'b11);
        tgt_base = is_jalr ? rs1data_de : pc_de;
        tgt_sum  = tgt_base + imm_de;
        tgt      = is_jalr ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;
        taken    = (br_type_de == 2'b01) ? comp_out : 1'b1;
        accept   = valid_de && ready_de && !stall_ex && (br_type_de != 2'b00);
    end

    // Next-state logic for the FSM, target register, exception and counters.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc_q;
        misalign_d    = 1'b0;
        branch_cnt_d  = branch_cnt_q;
        taken_cnt_d   = taken_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept && taken) begin
                    if (tgt[1]) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d       = StRedir;
                        redirect_pc_d = tgt;
                    end
                end
            end
            StRedir: begin
                if (FLUSH_CYC > 1) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (flush_cnt_q <= 4'd1) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear wins over a same-cycle increment; both saturate at all-ones.
        if (cnt_clr) begin
            branch_cnt_d = '0;
            taken_cnt_d  = '0;
        end else begin
            if (accept && (branch_cnt_q != '1)) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if ((state_q == StRedir) && (taken_cnt_q != '1)) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            flush_cnt_q   <= 4'd0;
            redirect_pc_q <= '0;
            misalign_q    <= 1'b0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_pc_q <= redirect_pc_d;
            misalign_q    <= misalign_d;
            branch_cnt_q  <= branch_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    // Outputs decoded from state; ready is held low while reset is asserted.
    always_comb begin
        ready_de       = rst_n && (state_q == StIdle);
        redirect_valid = (state_q == StRedir);
        flush_fe       = (state_q != StIdle);
        redirect_pc    = redirect_pc_q;
        misalign_exc   = misalign_q;
        branch_cnt     = branch_cnt_q;
        taken_cnt      = taken_cnt_q;
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl (XLEN=32, FLUSH_CYC=2, CNT_W=4).
// Inputs change on the falling edge; outputs are sampled on falling edges.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid_de;
    logic        ready_de;
    logic [1:0]  br_type_de;
    logic [31:0] pc_de;
    logic [31:0] imm_de;
    logic [31:0] rs1data_de;
    logic        comp_out;
    logic        stall_ex;
    logic        cnt_clr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_fe;
    logic        misalign_exc;
    logic [3:0]  branch_cnt;
    logic [3:0]  taken_cnt;

    int checks;
    int failures;

    branch_redirect_ctrl #(
        .XLEN      (32),
        .FLUSH_CYC (2),
        .CNT_W     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_de       (valid_de),
        .ready_de       (ready_de),
        .br_type_de     (br_type_de),
        .pc_de          (pc_de),
        .imm_de         (imm_de),
        .rs1data_de     (rs1data_de),
        .comp_out       (comp_out),
        .stall_ex       (stall_ex),
        .cnt_clr        (cnt_clr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_fe       (flush_fe),
        .misalign_exc   (misalign_exc),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        valid_de   = 1'b0;
        br_type_de = 2'b00;
        comp_out   = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    // Drive one offer on the next falling edge; it is seen by the next rising edge.
    task automatic offer(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic c);
        @(negedge clk);
        valid_de   = 1'b1;
        br_type_de = t;
        pc_de      = pc;
        imm_de     = imm;
        rs1data_de = rs1;
        comp_out   = c;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic clear_counters();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        stall_ex   = 1'b0;
        pc_de      = '0;
        imm_de     = '0;
        rs1data_de = '0;
        #12;
        checks++;
        if (ready_de !== 1'b0 || flush_fe !== 1'b0 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_in ready=%b flush=%b rv=%b exp 0 0 0",
                     ready_de, flush_fe, redirect_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_de !== 1'b1 || redirect_pc !== 32'h0 || branch_cnt !== 4'd0
            || taken_cnt !== 4'd0 || misalign_exc !== 1'b0) begin
            failures++;
            $display("FAIL reset_out ready=%b pc=%h bc=%0d tc=%0d mis=%b exp 1 0 0 0 0",
                     ready_de, redirect_pc, branch_cnt, taken_cnt, misalign_exc);
        end
    endtask

    task automatic test_not_taken();
        clear_counters();
        offer(2'b01, 32'h100, 32'h20, 32'h0, 1'b0);
        checks++;
        if (redirect_valid !== 1'b0 || ready_de !== 1'b1 || flush_fe !== 1'b0
            || branch_cnt !== 4'd1 || taken_cnt !== 4'd0) begin
            failures++;
            $display("FAIL not_taken rv=%b ready=%b flush=%b bc=%0d tc=%0d exp 0 1 0 1 0",
                     redirect_val_str(redirect_valid), ready_de, flush_fe, branch_cnt, taken_cnt);
        end
        // No bubble: a second not-taken branch is accepted straight away.
        offer(2'b01, 32'h100, 32'h20, 32'h0, 1'b0);
        checks++;
        if (branch_cnt !== 4'd2 || ready_de !== 1'b1) begin
            failures++;
            $display("FAIL not_taken_b2b bc=%0d ready=%b exp 2 1", branch_cnt, ready_de);
        end
        // A type-00 valid instruction is ignored.
        offer(2'b00, 32'h100, 32'h20, 32'h0, 1'b1);
        checks++;
        if (branch_cnt !== 4'd2 || redirect_valid !== 1'b0 || misalign_exc !== 1'b0) begin
            failures++;
            $display("FAIL type_none bc=%0d rv=%b mis=%b exp 2 0 0",
                     branch_cnt, redirect_valid, misalign_exc);
        end
    endtask

    function automatic logic redirect_val_str(input logic v);
        return v;
    endfunction

    task automatic test_taken();
        clear_counters();
        offer(2'b01, 32'h100, 32'h20, 32'h0, 1'b1);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || flush_fe !== 1'b1
            || ready_de !== 1'b0 || branch_cnt !== 4'd1 || taken_cnt !== 4'd0) begin
            failures++;
            $display("FAIL taken_redir rv=%b pc=%h flush=%b ready=%b bc=%0d tc=%0d exp 1 120 1 0 1 0",
                     redirect_valid, redirect_pc, flush_fe, ready_de, branch_cnt, taken_cnt);
        end
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b0 || flush_fe !== 1'b1 || ready_de !== 1'b0
            || taken_cnt !== 4'd1) begin
            failures++;
            $display("FAIL taken_flush rv=%b flush=%b ready=%b tc=%0d exp 0 1 0 1",
                     redirect_valid, flush_fe, ready_de, taken_cnt);
        end
        @(negedge clk);
        checks++;
        if (flush_fe !== 1'b0 || ready_de !== 1'b1 || redirect_pc !== 32'h120) begin
            failures++;
            $display("FAIL taken_done flush=%b ready=%b pc=%h exp 0 1 120",
                     flush_fe, ready_de, redirect_pc);
        end
    endtask

    task automatic test_targets();
        offer(2'b11, 32'h500, 32'h4, 32'h2001, 1'b0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004) begin
            failures++;
            $display("FAIL jalr_tgt rv=%b pc=%h exp 1 2004", redirect_valid, redirect_pc);
        end
        repeat (2) @(negedge clk);
        offer(2'b10, 32'hFFFF_FFF0, 32'h20, 32'h1234, 1'b0);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10) begin
            failures++;
            $display("FAIL jal_wrap rv=%b pc=%h exp 1 10", redirect_valid, redirect_pc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_misalign();
        clear_counters();
        offer(2'b10, 32'h100, 32'h6, 32'h0, 1'b0);
        checks++;
        if (misalign_exc !== 1'b1 || redirect_valid !== 1'b0 || ready_de !== 1'b1
            || flush_fe !== 1'b0 || branch_cnt !== 4'd1) begin
            failures++;
            $display("FAIL misalign mis=%b rv=%b ready=%b flush=%b bc=%0d exp 1 0 1 0 1",
                     misalign_exc, redirect_valid, ready_de, flush_fe, branch_cnt);
        end
        @(negedge clk);
        checks++;
        if (misalign_exc !== 1'b0 || taken_cnt !== 4'd0 || redirect_pc !== 32'h10) begin
            failures++;
            $display("FAIL misalign_end mis=%b tc=%0d pc=%h exp 0 0 10",
                     misalign_exc, taken_cnt, redirect_pc);
        end
    endtask

    task automatic test_stall();
        clear_counters();
        stall_ex = 1'b1;
        offer(2'b10, 32'h300, 32'h40, 32'h0, 1'b0);
        stall_ex = 1'b0;
        checks++;
        if (redirect_valid !== 1'b0 || branch_cnt !== 4'd0 || ready_de !== 1'b1) begin
            failures++;
            $display("FAIL stall_block rv=%b bc=%0d ready=%b exp 0 0 1",
                     redirect_valid, branch_cnt, ready_de);
        end
        offer(2'b10, 32'h300, 32'h40, 32'h0, 1'b0);
        stall_ex = 1'b1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h340) begin
            failures++;
            $display("FAIL stall_redir rv=%b pc=%h exp 1 340", redirect_valid, redirect_pc);
        end
        @(negedge clk);
        checks++;
        if (flush_fe !== 1'b1 || ready_de !== 1'b0) begin
            failures++;
            $display("FAIL stall_flush flush=%b ready=%b exp 1 0", flush_fe, ready_de);
        end
        @(negedge clk);
        checks++;
        if (flush_fe !== 1'b0 || ready_de !== 1'b1) begin
            failures++;
            $display("FAIL stall_flush_end flush=%b ready=%b exp 0 1", flush_fe, ready_de);
        end
        stall_ex = 1'b0;
    endtask

    task automatic test_reset_in_flush();
        offer(2'b10, 32'h400, 32'h8, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (flush_fe !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_flush flush=%b exp 1", flush_fe);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (flush_fe !== 1'b0 || redirect_valid !== 1'b0 || ready_de !== 1'b0
            || redirect_pc !== 32'h0 || branch_cnt !== 4'd0 || taken_cnt !== 4'd0) begin
            failures++;
            $display("FAIL async_reset flush=%b rv=%b ready=%b pc=%h bc=%0d tc=%0d exp 0 0 0 0 0 0",
                     flush_fe, redirect_valid, ready_de, redirect_pc, branch_cnt, taken_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_de !== 1'b1 || flush_fe !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b flush=%b exp 1 0", ready_de, flush_fe);
        end
    endtask

    task automatic test_saturate_clear();
        clear_counters();
        for (int i = 0; i < 20; i++) begin
            offer(2'b10, 32'h800, 32'h10, 32'h0, 1'b0);
            repeat (2) @(negedge clk);
        end
        checks++;
        if (branch_cnt !== 4'd15 || taken_cnt !== 4'd15) begin
            failures++;
            $display("FAIL saturate bc=%0d tc=%0d exp 15 15", branch_cnt, taken_cnt);
        end
        @(negedge clk);
        valid_de   = 1'b1;
        br_type_de = 2'b10;
        pc_de      = 32'h800;
        imm_de     = 32'h10;
        cnt_clr    = 1'b1;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (branch_cnt !== 4'd0 || taken_cnt !== 4'd0 || redirect_valid !== 1'b1) begin
            failures++;
            $display("FAIL clr_priority bc=%0d tc=%0d rv=%b exp 0 0 1",
                     branch_cnt, taken_cnt, redirect_valid);
        end
        @(negedge clk);
        checks++;
        if (taken_cnt !== 4'd1 || branch_cnt !== 4'd0) begin
            failures++;
            $display("FAIL clr_after bc=%0d tc=%0d exp 0 1", branch_cnt, taken_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_not_taken();
        test_taken();
        test_targets();
        test_misalign();
        test_stall();
        test_reset_in_flush();
        test_saturate_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
